// File: rtl/pulsar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulsar_pkg
// Description : Constants and helpers shared by counter-side and PWM-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pulsar_pkg;

    localparam int c_default_counter_width = 16;

    // Channel-index width; never narrower than one bit so a single-channel
    // build still has a legal index port.
    function automatic int chan_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM channel: shadow/active duty+enable, compare, output flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pulsar_pkg::*;
#(
    parameter int COUNTER_WIDTH = c_default_counter_width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] i_counter,
    input  logic                     i_overflow,
    input  logic                     i_wr_strobe,
    input  logic [COUNTER_WIDTH-1:0] i_wr_duty,
    input  logic                     i_wr_enable,
    output logic                     o_pending,
    output logic                     o_pwm
);

    logic [COUNTER_WIDTH-1:0] r_shadow_duty;
    logic                     r_shadow_en;
    logic [COUNTER_WIDTH-1:0] r_active_duty;
    logic                     r_active_en;
    logic                     r_pending;
    logic                     r_pwm;

    logic                     w_use_shadow;
    logic [COUNTER_WIDTH-1:0] w_eff_duty;
    logic                     w_eff_en;

    // On the commit cycle the shadow value already drives the compare, so the
    // new duty governs the period that starts at counter==0.
    assign w_use_shadow = i_overflow & r_pending;
    assign w_eff_duty   = w_use_shadow ? r_shadow_duty : r_active_duty;
    assign w_eff_en     = w_use_shadow ? r_shadow_en   : r_active_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_duty <= '0;
            r_shadow_en   <= 1'b0;
            r_active_duty <= '0;
            r_active_en   <= 1'b0;
            r_pending     <= 1'b0;
            r_pwm         <= 1'b0;
        end else begin
            r_pwm <= w_eff_en & (i_counter < w_eff_duty);
            if (w_use_shadow) begin
                r_active_duty <= r_shadow_duty;
                r_active_en   <= r_shadow_en;
                r_pending     <= 1'b0;
            end else if (i_wr_strobe) begin
                r_shadow_duty <= i_wr_duty;
                r_shadow_en   <= i_wr_enable;
                r_pending     <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_pwm     = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : pwm_compare
// Description : Multi-channel PWM with period-boundary commit of duty/enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_compare
    import pulsar_pkg::*;
#(
    parameter int COUNTER_WIDTH = c_default_counter_width,
    parameter int CHANNELS      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [COUNTER_WIDTH-1:0]             counter,
    input  logic                                 overflow,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [chan_idx_width(CHANNELS)-1:0]  wr_chan,
    input  logic [COUNTER_WIDTH-1:0]             wr_duty,
    input  logic                                 wr_enable,
    output logic                                 commit_pending,
    output logic [CHANNELS-1:0]                  pwm
);

    localparam int CW = chan_idx_width(CHANNELS);

    logic                r_ready_arm;
    logic                w_wr_fire;
    logic [CHANNELS-1:0] w_wr_strobe;
    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_pwm;

    // Held low through reset, then high except on commit cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_arm <= 1'b0;
        end else begin
            r_ready_arm <= 1'b1;
        end
    end

    assign wr_ready  = r_ready_arm & ~overflow;
    assign w_wr_fire = wr_valid & wr_ready;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            assign w_wr_strobe[g] = w_wr_fire & (wr_chan == CW'(g));

            pwm_channel #(
                .COUNTER_WIDTH (COUNTER_WIDTH)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_counter   (counter),
                .i_overflow  (overflow),
                .i_wr_strobe (w_wr_strobe[g]),
                .i_wr_duty   (wr_duty),
                .i_wr_enable (wr_enable),
                .o_pending   (w_pending[g]),
                .o_pwm       (w_pwm[g])
            );
        end
    endgenerate

    assign commit_pending = |w_pending;
    assign pwm            = w_pwm;

endmodule
`default_nettype wire

// File: tb/tb_pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_compare
// Description : Scoreboard bench for pwm_compare driven by a real wrapping counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_compare;

    localparam int W  = 4;
    localparam int CH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] counter = 4'd5;
    logic         overflow;
    logic         wr_valid;
    logic         wr_ready;
    logic [1:0]   wr_chan;
    logic [W-1:0] wr_duty;
    logic         wr_enable;
    logic         commit_pending;
    logic [CH-1:0] pwm;

    logic         wr3_valid;
    logic         wr3_ready;
    logic [1:0]   wr3_chan;
    logic [W-1:0] wr3_duty;
    logic         wr3_enable;
    logic         commit_pending3;
    logic [2:0]   pwm3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) counter <= counter + 4'd1;
    assign overflow = (counter == '0);

    pwm_compare #(.COUNTER_WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst_n(rst_n), .counter(counter), .overflow(overflow),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
        .wr_duty(wr_duty), .wr_enable(wr_enable),
        .commit_pending(commit_pending), .pwm(pwm)
    );

    pwm_compare #(.COUNTER_WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .counter(counter), .overflow(overflow),
        .wr_valid(wr3_valid), .wr_ready(wr3_ready), .wr_chan(wr3_chan),
        .wr_duty(wr3_duty), .wr_enable(wr3_enable),
        .commit_pending(commit_pending3), .pwm(pwm3)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: per-channel shadow/active records, expected pwm queued
    int unsigned   m_sd[CH], m_ad[CH];
    bit            m_se[CH], m_ae[CH], m_pend[CH];
    bit            m_live;
    logic [CH-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_sd[i] = 0; m_ad[i] = 0; m_se[i] = 0; m_ae[i] = 0; m_pend[i] = 0;
            end
            m_live = 0;
            exp_q.delete();
        end else begin
            logic [CH-1:0] e;
            bit ready;
            for (int i = 0; i < CH; i++) begin
                if (overflow && m_pend[i]) e[i] = m_se[i] && (int'(counter) < int'(m_sd[i]));
                else                       e[i] = m_ae[i] && (int'(counter) < int'(m_ad[i]));
            end
            exp_q.push_back(e);
            ready = m_live && !overflow;
            if (wr_valid && ready && int'(wr_chan) < CH) begin
                m_sd[wr_chan]   = wr_duty;
                m_se[wr_chan]   = wr_enable;
                m_pend[wr_chan] = 1;
            end
            if (overflow) begin
                for (int i = 0; i < CH; i++) begin
                    if (m_pend[i]) begin
                        m_ad[i] = m_sd[i]; m_ae[i] = m_se[i]; m_pend[i] = 0;
                    end
                end
            end
            m_live = 1;
        end
    end

    // Monitor: DUT outputs compared against the model away from the active edge
    always @(negedge clk) begin
        logic [CH-1:0] exp_pwm;
        bit any_pend;
        if (!rst_n) begin
            chk("rst_pwm", int'(pwm), 0);
            chk("rst_wr_ready", int'(wr_ready), 0);
            chk("rst_commit_pending", int'(commit_pending), 0);
        end else begin
            exp_pwm = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            any_pend = 0;
            for (int i = 0; i < CH; i++) any_pend |= m_pend[i];
            chk("pwm", int'(pwm), int'(exp_pwm));
            chk("wr_ready", int'(wr_ready), int'(m_live && !overflow));
            chk("commit_pending", int'(commit_pending), int'(any_pend));
        end
    end

    task automatic wr(input int ch, input int duty, input bit en);
        bit acc = 0;
        int n = 0;
        wr_valid = 1'b1; wr_chan = 2'(ch); wr_duty = 4'(duty); wr_enable = en;
        do begin
            acc = wr_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 40);
        wr_valid = 1'b0;
        if (!acc) chk("wr_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (int'(counter) != v && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (int'(counter) != v) chk("wait_cnt_timeout", int'(counter), v);
    endtask

    // Counts high cycles of one full period starting at the next counter==0
    task automatic count_highs(input int ch, output int n);
        n = 0;
        wait_cnt(0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n += int'(pwm[ch]);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_chan = '0; wr_duty = '0; wr_enable = 1'b0;
        wr3_valid = 1'b0; wr3_chan = '0; wr3_duty = '0; wr3_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ch0 duty 4 written mid-period
        wait_cnt(6);
        wr(0, 4, 1);
        chk("ch0_pending_after_wr", int'(commit_pending), 1);
        count_highs(0, n);  chk("ch0_duty4_p1", n, 4);
        count_highs(0, n);  chk("ch0_duty4_p2", n, 4);

        // write held across the commit cycle
        wait_cnt(0);
        chk("wr_ready_on_overflow", int'(wr_ready), 0);
        wr(1, 5, 1);
        chk("held_wr_still_pending", int'(commit_pending), 1);
        count_highs(1, n);  chk("ch1_duty5", n, 5);

        // last write before commit wins
        wait_cnt(4);
        wr(1, 3, 1);
        wr(1, 9, 1);
        count_highs(1, n);  chk("ch1_last_wins", n, 9);

        // ch2 boundaries
        wait_cnt(3);
        wr(2, 0, 1);
        count_highs(2, n);  chk("ch2_duty0", n, 0);
        wr(2, 15, 1);
        count_highs(2, n);  chk("ch2_duty15", n, 15);
        wr(2, 8, 0);
        count_highs(2, n);  chk("ch2_disabled", n, 0);

        // top channel while others pending; out-of-range index on the 3-channel build
        wait_cnt(3);
        wr(0, 2, 1);
        wr(3, 6, 1);
        wr3_valid = 1'b1; wr3_chan = 2'd3; wr3_duty = 4'd6; wr3_enable = 1'b1;
        chk("dut3_ready", int'(wr3_ready), 1);
        @(negedge clk);
        wr3_valid = 1'b0;
        chk("dut3_no_pending", int'(commit_pending3), 0);
        count_highs(3, n);  chk("ch3_duty6", n, 6);
        chk("dut3_pwm_quiet", int'(pwm3), 0);
        chk("dut3_still_no_pending", int'(commit_pending3), 0);

        // randomized traffic checked by the scoreboard
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            wr($urandom_range(0, CH - 1), $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0));
        end

        // reset mid-period with a pending update
        wait_cnt(2);
        wr(0, 4, 1);
        count_highs(0, n);  chk("pre_reset_duty4", n, 4);
        wait_cnt(5);
        wr(0, 10, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_pending", int'(commit_pending), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_highs(0, n);  chk("post_reset_p1", n, 0);
        count_highs(0, n);  chk("post_reset_p2", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
